// File: rtl/sky_acc_cpu_p.sv
// sky_acc_cpu_p: accumulator CPU with writable program memory,
// zero/carry flags, jumps, run/idle control and illegal-opcode trap.
module sky_acc_cpu_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              run,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              zero,
    output logic              carry,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_OPERAND, S_EXEC, S_HALT
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] word;
    logic [3:0]        opcode, opcode_n;
    logic [DATA_W-1:0] operand, operand_n;
    logic [DATA_W-1:0] acc_n;
    logic [ADDR_W-1:0] pc_n;
    logic              zero_n, carry_n, illegal_n;
    logic              wr_zero;
    logic [DATA_W:0]   sum, dif;

    function automatic logic is_two(input logic [3:0] o);
        return (o >= 4'h1 && o <= 4'h6) || (o >= 4'hA && o <= 4'hC);
    endfunction

    function automatic logic is_stop(input logic [3:0] o);
        return o == 4'hD || o == 4'hE || o == 4'hF;
    endfunction

    assign word   = mem[pc];
    assign halted = (state == S_HALT);
    assign sum    = {1'b0, acc} + {1'b0, operand};
    assign dif    = {1'b0, acc} - {1'b0, operand};

    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (rst)           state <= S_IDLE;
        else if (!prog_we) state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    state_n = run ? S_FETCH : S_IDLE;
            S_FETCH:   state_n = is_two(word[3:0]) ? S_OPERAND : S_EXEC;
            S_OPERAND: state_n = S_EXEC;
            S_EXEC: begin
                if (is_stop(opcode)) state_n = S_HALT;
                else                 state_n = run ? S_FETCH : S_IDLE;
            end
            S_HALT:    state_n = S_HALT;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        acc_n     = acc;
        pc_n      = pc;
        zero_n    = zero;
        carry_n   = carry;
        illegal_n = illegal;
        opcode_n  = opcode;
        operand_n = operand;
        wr_zero   = 1'b0;
        case (state)
            S_FETCH: begin
                opcode_n = word[3:0];
                pc_n     = pc + ADDR_W'(1);
            end
            S_OPERAND: begin
                operand_n = word;
                pc_n      = pc + ADDR_W'(1);
            end
            S_EXEC: begin
                case (opcode)
                    4'h1: begin acc_n = operand; carry_n = 1'b0; end
                    4'h2: {carry_n, acc_n} = sum;
                    4'h3: begin
                        acc_n   = dif[DATA_W-1:0];
                        carry_n = dif[DATA_W];
                    end
                    4'h4: begin acc_n = acc & operand; carry_n = 1'b0; end
                    4'h5: begin acc_n = acc | operand; carry_n = 1'b0; end
                    4'h6: begin acc_n = acc ^ operand; carry_n = 1'b0; end
                    4'h7: begin acc_n = ~acc; carry_n = 1'b0; end
                    4'h8: begin
                        carry_n = acc[DATA_W-1];
                        acc_n   = acc << 1;
                    end
                    4'h9: begin
                        carry_n = acc[0];
                        acc_n   = acc >> 1;
                    end
                    4'hA: pc_n = operand[ADDR_W-1:0];
                    4'hB: if (zero)  pc_n = operand[ADDR_W-1:0];
                    4'hC: if (carry) pc_n = operand[ADDR_W-1:0];
                    4'hE, 4'hF: illegal_n = 1'b1;
                    default: ;
                endcase
                // jumps test the pre-EXEC flags; only ALU ops rewrite zero
                wr_zero = (opcode >= 4'h1 && opcode <= 4'h9);
                if (wr_zero) zero_n = (acc_n == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            pc      <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            illegal <= 1'b0;
            opcode  <= '0;
            operand <= '0;
        end else if (!prog_we) begin
            acc     <= acc_n;
            pc      <= pc_n;
            zero    <= zero_n;
            carry   <= carry_n;
            illegal <= illegal_n;
            opcode  <= opcode_n;
            operand <= operand_n;
        end
    end

endmodule

// File: doc/sky_acc_cpu_p.md
Name: sky_acc_cpu_p

Overview:
- Parametrised accumulator CPU, next generation of the 8-bit tiny-tapeout accumulator core.
- Program memory is writable through a load port and is generic in data width and depth.
- Adds conditional/unconditional jumps, zero/carry flags, variable-length instructions, a run/idle control and an illegal-opcode trap.
- Sits behind the tt_um top wrapper, which maps ui/uio pins onto its load and run ports.

Parameters:
- DATA_W, 8: accumulator, operand and memory word width; minimum 8.
- ADDR_W, 5: program address width; memory depth is 2**ADDR_W words.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  program-memory write enable.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  DATA_W  write data.
- run  in  1  execute enable.
- acc  out  DATA_W  accumulator.
- pc  out  ADDR_W  program counter.
- zero  out  1  zero flag.
- carry  out  1  carry/borrow flag.
- halted  out  1  core is in HALT.
- illegal  out  1  halt was caused by an illegal opcode.

Behaviour:
- Reset, when rst=1 at a clock edge: acc=0, pc=0, zero=0, carry=0, halted=0, illegal=0, state=IDLE. Memory contents are not reset. rst overrides every other input, including in the middle of an instruction.
- prog_we=1: mem[prog_addr]<=prog_data. In the same cycle all core state (FSM, pc, acc, flags, latched opcode/operand) is frozen. Execution resumes unchanged on the next cycle with prog_we=0.
- Memory read is asynchronous: the word at mem[pc] is available in the same cycle.
- Opcode is word[3:0]. Upper bits of an opcode word are ignored.
- States and transitions:
  - IDLE: go to FETCH when run=1; otherwise stay.
  - FETCH: opcode<=mem[pc]; pc<=pc+1. Two-word opcodes go to OPERAND; one-word opcodes go to EXEC.
  - OPERAND: operand<=mem[pc]; pc<=pc+1; go to EXEC.
  - EXEC: perform the operation. If the result is halt, go to HALT. Otherwise go to FETCH if run=1, else IDLE.
  - HALT: sticky; halted=1. Left only by rst.
- run is sampled only in IDLE and at the end of EXEC. Deasserting run never aborts an instruction already in progress.
- Latency: one-word instructions take 2 cycles; two-word instructions take 3 cycles.
- pc arithmetic is modulo 2**ADDR_W; incrementing from the top address wraps to 0.
- Two-word opcodes:
  - 1 LDI: acc=op.
  - 2 ADD: {carry,acc}=acc+op.
  - 3 SUB: acc=acc-op; carry=1 iff acc<op (unsigned borrow).
  - 4 AND: acc=acc&op.
  - 5 OR: acc=acc|op.
  - 6 XOR: acc=acc^op.
  - A JMP: pc=op[ADDR_W-1:0].
  - B JZ: jump if zero=1.
  - C JC: jump if carry=1.
- One-word opcodes:
  - 0 NOP.
  - 7 NOT: acc=~acc.
  - 8 SHL: carry=acc[MSB]; acc=acc<<1.
  - 9 SHR: carry=acc[0]; acc=acc>>1.
  - D HALT.
  - E, F: illegal; halted=1 and illegal=1.
- Flag rules:
  - zero is updated by every acc-writing opcode (1–9) to (new acc==0).
  - carry is updated by ADD, SUB, SHL and SHR; cleared by LDI, AND, OR, XOR and NOT.
  - NOP, jumps and HALT leave both flags unchanged.
  - Conditional jumps test the flags as they stand before EXEC.
- Arithmetic wraps at DATA_W bits. An untaken jump still consumes its operand word (pc advances by 2).

Test Plan (DATA_W=8, ADDR_W=5):
- Program mem[0..4]=01,05,02,03,0D; run=1 from reset -> acc=0x08, zero=0, carry=0, halted=1 and pc=5 exactly 8 cycles after leaving IDLE.
- Program 01,FF,02,01,0D -> acc=0x00, zero=1, carry=1. Replace 02,01 with 08 (SHL) -> acc=0xFE, carry=1, zero=0.
- Loop 01,03 | @2: 03,01,0B,08,0A,02 | @8: 0D -> SUB executes 3 times; final acc=0, zero=1, pc=9, halted=1, illegal=0.
- Pulse prog_we for 1 cycle during OPERAND of ADD, and separately drop run during EXEC -> the write lands; pc/acc are unchanged that cycle; the ADD completes one cycle late; the core parks in IDLE with pc at the next instruction; raising run resumes correctly.
- mem[31]=00 (NOP), mem[0]=0E, start via JMP 0x1F -> pc wraps 31→0, then halted=1, illegal=1, acc unchanged.
- Assert rst during EXEC of LDI 0x55 with run held 1 -> next cycle acc=0, pc=0, flags=0, halted=0, state IDLE; FETCH the cycle after, and the program re-executes from 0.
